// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared constants, fetch FSM state type and branch-target helper
// Contents:
//   INSTR_W, PC_STEP, BR_PIPE_OFS  instruction width, sequential step, branch pipeline offset
//   fetch_state_e                  IDLE / REQ / DROP fetch FSM states
//   br_target()                    br_pc + 8 + sext(offset)<<2, word aligned
package fetch_unit_pkg;
  localparam int INSTR_W = 32;
  localparam int PC_STEP = 4;
  localparam int BR_PIPE_OFS = 8;
  typedef enum logic [1:0] {IDLE, REQ, DROP} fetch_state_e;
  function automatic logic [31:0] br_target(input logic [31:0] pc, input logic [23:0] ofs);
    return (pc + 32'(BR_PIPE_OFS) + {{6{ofs[23]}}, ofs, 2'b00}) & 32'hFFFF_FFFC;
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: 2-entry synchronous FIFO of {pc, instr} with flush
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   i_push, i_pop    write / read strobes, both honoured in the same cycle
//   i_flush          empties the FIFO, overrides push and pop
//   i_instr, i_pc    entry written on push
//   o_instr, o_pc    head entry
//   o_count          number of valid entries (0..2)
module fetch_fifo #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_flush,
  input  logic [DW-1:0] i_instr,
  input  logic [AW-1:0] i_pc,
  output logic [DW-1:0] o_instr,
  output logic [AW-1:0] o_pc,
  output logic [1:0]    o_count
);
  logic [DW-1:0] r_instr [2];
  logic [AW-1:0] r_pc [2];
  logic          r_rd;
  logic          r_wr;
  logic [1:0]    r_count;
  logic          w_push;
  logic          w_pop;

  // pushing into a full FIFO is only legal when the head leaves the same cycle
  assign w_pop  = i_pop && r_count != 2'd0;
  assign w_push = i_push && (r_count != 2'd2 || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        r_instr[i] <= '0;
        r_pc[i]    <= '0;
      end
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_count <= 2'd0;
    end else if (i_flush) begin
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push) begin
        r_instr[r_wr] <= i_instr;
        r_pc[r_wr]    <= i_pc;
        r_wr          <= ~r_wr;
      end
      if (w_pop) r_rd <= ~r_rd;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  assign o_instr = r_instr[r_rd];
  assign o_pc    = r_pc[r_rd];
  assign o_count = r_count;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with single-outstanding imem port, 2-entry buffer and branch redirect
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   imem_req, imem_addr              fetch request and word address, held until ack
//   imem_ack, imem_rdata             request completion and fetched word
//   instr_valid, instr_out, pc_out   head of the instruction buffer towards decode
//   stall                            decoder back-pressure
//   br_en, br_offset, br_pc          redirect pulse, signed word offset, branching pc
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int                FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  pc_out,
  input  logic               stall,
  input  logic               br_en,
  input  logic [23:0]        br_offset,
  input  logic [ADDR_W-1:0]  br_pc
);
  fetch_state_e      r_state;
  fetch_state_e      w_state_nxt;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] w_fetch_pc_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [ADDR_W-1:0] w_target;
  logic [1:0]        w_count;
  logic [1:0]        w_cnt_nxt;
  logic              w_ack;
  logic              w_push;
  logic              w_pop;

  assign w_target    = ADDR_W'(br_target(32'(br_pc), br_offset));
  assign imem_req    = r_state != IDLE;
  assign imem_addr   = r_addr;
  assign instr_valid = w_count != 2'd0;
  // a redirect wins over everything: no pop, no push, acked data is discarded
  assign w_ack       = imem_ack && r_state != IDLE;
  assign w_pop       = instr_valid && !stall && !br_en;
  assign w_push      = w_ack && r_state == REQ && !br_en;
  assign w_cnt_nxt   = w_count + {1'b0, w_push} - {1'b0, w_pop};

  // r_addr is separate from r_fetch_pc so a DROP keeps the old address on the bus
  // while fetch_pc already points at the redirect target
  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_addr_nxt     = r_addr;
    if (br_en) begin
      w_fetch_pc_nxt = w_target;
      w_state_nxt    = (r_state != IDLE && !w_ack) ? DROP : IDLE;
    end else if (r_state == IDLE) begin
      w_state_nxt = (w_count < 2'(FIFO_DEPTH)) ? REQ : IDLE;
      w_addr_nxt  = r_fetch_pc;
    end else if (w_ack) begin
      w_fetch_pc_nxt = (r_state == REQ) ? r_fetch_pc + ADDR_W'(PC_STEP) : r_fetch_pc;
      w_state_nxt    = (r_state == REQ && w_cnt_nxt < 2'(FIFO_DEPTH)) ? REQ : IDLE;
      w_addr_nxt     = w_fetch_pc_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_fetch_pc <= RESET_PC;
      r_addr     <= RESET_PC;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_addr     <= w_addr_nxt;
    end
  end

  fetch_fifo #(.AW(ADDR_W), .DW(INSTR_W)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (br_en),
    .i_instr (imem_rdata),
    .i_pc    (r_fetch_pc),
    .o_instr (instr_out),
    .o_pc    (pc_out),
    .o_count (w_count)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scoreboard bench for fetch_unit
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_ack, instr_valid, stall, br_en;
  logic [31:0] imem_addr, imem_rdata, instr_out, pc_out, br_pc;
  logic [23:0] br_offset;
  logic        r_ack, f_ack;
  logic        imem_req2, instr_valid2;
  logic        imem_ack2;
  logic [31:0] imem_addr2, imem_rdata2, instr_out2, pc_out2;
  int          lat, wcnt, wcnt2, n_ack, base, n2;
  int          checks, errors;
  logic        chk2;
  logic [31:0] q[$];
  logic [31:0] e;

  always #5 clk = ~clk;
  assign imem_ack = r_ack | f_ack;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
    .instr_out(instr_out), .pc_out(pc_out), .stall(stall), .br_en(br_en),
    .br_offset(br_offset), .br_pc(br_pc)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_ack(imem_ack2), .imem_rdata(imem_rdata2), .instr_valid(instr_valid2),
    .instr_out(instr_out2), .pc_out(pc_out2), .stall(1'b0), .br_en(1'b0),
    .br_offset(24'h0), .br_pc(32'h0)
  );

  // memory: ack after lat full cycles of req, data = addr ^ A5A5_0000
  always @(negedge clk) begin
    if (!rst_n || !imem_req) begin
      r_ack = 1'b0;
      wcnt = 0;
    end else if (wcnt == lat) begin
      r_ack = 1'b1;
      imem_rdata = imem_addr ^ 32'hA5A5_0000;
      wcnt = 0;
      n_ack++;
    end else begin
      r_ack = 1'b0;
      wcnt++;
    end
  end

  always @(negedge clk) begin
    if (!rst_n || !imem_req2) begin
      imem_ack2 = 1'b0;
      wcnt2 = 0;
    end else if (wcnt2 == 1) begin
      imem_ack2 = 1'b1;
      imem_rdata2 = imem_addr2 ^ 32'hA5A5_0000;
      wcnt2 = 0;
    end else begin
      imem_ack2 = 1'b0;
      wcnt2++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // scoreboard pop on every consumed entry, then advance to mid-cycle of the next clock
  task automatic step();
    if (rst_n && instr_valid && !stall && !br_en) begin
      check("sb_nonempty", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        check("sb_pc", pc_out, e);
        check("sb_instr", instr_out, e ^ 32'hA5A5_0000);
      end
    end
    if (chk2 && instr_valid2 && n2 < 3) begin
      check("wrap_pc", pc_out2, 32'hFFFF_FFF8 + 32'(n2) * 32'd4);
      check("wrap_instr", instr_out2, (32'hFFFF_FFF8 + 32'(n2) * 32'd4) ^ 32'hA5A5_0000);
      n2++;
    end
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    q.delete();
    base = n_ack;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; br_en = 1'b0; br_pc = '0; br_offset = '0;
    f_ack = 1'b0; lat = 1; n_ack = 0; n2 = 0; chk2 = 1'b0; checks = 0; errors = 0;
    step();
    step();
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr_out, 32'h0);
    check("rst_pc", pc_out, 32'h0);
    // streaming with 1-cycle memory
    q.push_back(32'h0); q.push_back(32'h4); q.push_back(32'h8);
    chk2 = 1'b1;
    rst_n = 1'b1;
    step();
    check("t1_req_c1", 32'(imem_req), 32'd1);
    check("t1_addr_c1", imem_addr, 32'h0);
    step();
    check("t1_addr_c2", imem_addr, 32'h0);
    step();
    check("t1_addr_c3", imem_addr, 32'h4);
    check("t1_valid_c3", 32'(instr_valid), 32'd1);
    check("t1_pc_c3", pc_out, 32'h0);
    step();
    check("t1_valid_c4", 32'(instr_valid), 32'd0);
    step();
    check("t1_addr_c5", imem_addr, 32'h8);
    repeat (3) step();
    check("t1_drain", 32'(q.size()), 32'd0);
    // stall fills the buffer and blocks requests
    stall = 1'b1;
    do_reset();
    q.push_back(32'h0); q.push_back(32'h4);
    repeat (10) step();
    check("t2_req_off", 32'(imem_req), 32'd0);
    check("t2_acks", 32'(n_ack - base), 32'd2);
    check("t2_valid", 32'(instr_valid), 32'd1);
    check("t2_head", pc_out, 32'h0);
    stall = 1'b0;
    step();
    step();
    check("t2_resume_req", 32'(imem_req), 32'd1);
    check("t2_resume_addr", imem_addr, 32'h8);
    check("t2_drain", 32'(q.size()), 32'd0);
    // redirect with full buffer and no outstanding request
    stall = 1'b1;
    do_reset();
    repeat (10) step();
    br_en = 1'b1; br_pc = 32'h100; br_offset = 24'hFFFFFE; q.delete();
    step();
    br_en = 1'b0;
    check("t3_flush", 32'(instr_valid), 32'd0);
    check("t3_req_idle", 32'(imem_req), 32'd0);
    step();
    check("t3_req", 32'(imem_req), 32'd1);
    check("t3_addr", imem_addr, 32'h100);
    stall = 1'b0;
    q.push_back(32'h100);
    repeat (3) step();
    check("t3_drain", 32'(q.size()), 32'd0);
    // redirect while a slow request is outstanding
    lat = 3;
    do_reset();
    step();
    br_en = 1'b1; br_pc = 32'h38; br_offset = 24'h0;
    step();
    br_en = 1'b0;
    check("t4_drop_req", 32'(imem_req), 32'd1);
    check("t4_drop_addr", imem_addr, 32'h0);
    repeat (3) step();
    check("t4_idle", 32'(imem_req), 32'd0);
    step();
    check("t4_addr40", imem_addr, 32'h40);
    step();
    br_en = 1'b1; br_pc = 32'h200; br_offset = 24'h10; q.delete(); q.push_back(32'h248);
    step();
    br_en = 1'b0;
    check("t4_drop2_req", 32'(imem_req), 32'd1);
    check("t4_drop2_addr", imem_addr, 32'h40);
    step();
    step();
    check("t4_idle2", 32'(imem_req), 32'd0);
    check("t4_no40", 32'(instr_valid), 32'd0);
    step();
    check("t4_tgt_req", 32'(imem_req), 32'd1);
    check("t4_tgt_addr", imem_addr, 32'h248);
    lat = 1;
    step();
    step();
    check("t4_tgt_valid", 32'(instr_valid), 32'd1);
    step();
    check("t4_drain", 32'(q.size()), 32'd0);
    // redirect on the ack cycle
    do_reset();
    step();
    step();
    br_en = 1'b1; br_pc = 32'h1000; br_offset = 24'h1; q.delete(); q.push_back(32'h100C);
    step();
    br_en = 1'b0;
    check("t5_discard", 32'(instr_valid), 32'd0);
    check("t5_req_idle", 32'(imem_req), 32'd0);
    step();
    check("t5_addr", imem_addr, 32'h100C);
    repeat (3) step();
    check("t5_drain", 32'(q.size()), 32'd0);
    // reset mid-request, then a late ack while idle
    stall = 1'b1;
    do_reset();
    repeat (3) step();
    check("t7_pre_valid", 32'(instr_valid), 32'd1);
    check("t7_pre_instr", instr_out, 32'hA5A5_0000);
    check("t7_pre_addr", imem_addr, 32'h4);
    rst_n = 1'b0;
    #1;
    check("t7_req", 32'(imem_req), 32'd0);
    check("t7_addr", imem_addr, 32'h0);
    check("t7_valid", 32'(instr_valid), 32'd0);
    check("t7_instr", instr_out, 32'h0);
    check("t7_pc", pc_out, 32'h0);
    step();
    q.delete();
    f_ack = 1'b1;
    rst_n = 1'b1;
    step();
    f_ack = 1'b0;
    check("t7_late_ack", 32'(instr_valid), 32'd0);
    check("t7_req_c1", 32'(imem_req), 32'd1);
    check("t7_addr_c1", imem_addr, 32'h0);
    stall = 1'b0;
    q.push_back(32'h0);
    step();
    check("t7_valid_c2", 32'(instr_valid), 32'd0);
    repeat (2) step();
    check("t7_drain", 32'(q.size()), 32'd0);
    check("wrap_count", 32'(n2), 32'd3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
